// File: rtl/anim_pkg.sv
// anim_pkg: shared types for the sprite-animation sequencer.
// Provides the playback-mode and FSM-state enums plus a mode decoder that
// folds the unused encoding onto LOOP.
package anim_pkg;

    typedef enum logic [1:0] {
        LOOP     = 2'd0,
        PINGPONG = 2'd1,
        ONESHOT  = 2'd2
    } anim_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } anim_state_t;

    // Encoding 3 has no meaning of its own and plays as a plain loop.
    function automatic anim_mode_t decode_mode(input logic [1:0] raw);
        anim_mode_t m;
        case (raw)
            2'd1:    m = PINGPONG;
            2'd2:    m = ONESHOT;
            default: m = LOOP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/anim_sequencer_frame_tick.sv
// frame_tick: TICKS-cycle prescaler producing a one-cycle frame tick.
// Ports: clk, rst (sync, active high), clr (sync clear to 0, wins over en),
//        en (count enable), tick (high while en and count == TICKS-1).
module frame_tick #(
    parameter int TICKS = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    import anim_pkg::*;

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// anim_sequencer: steps a sprite frame index in loop / ping-pong / one-shot
// mode, forms the frame-memory address and registers the returned pixel.
// Ports: clk, rst (sync, active high); start/stop pulses; mode (sampled on
//        start); ram_addr_x/y pixel coordinates; rom_addr = {frame, y, x};
//        rom_data pixel in; ram_data registered pixel; frame; busy; done.
// Optional: `ANIM_PAUSE_EN adds a pause input that freezes playback in RUN.
module anim_sequencer #(
    parameter int FRAMES = 8,
    parameter int TICKS  = 25_000_000,
    parameter int PIX_W  = 16,
    parameter int ADDR_W = 8,
    parameter int FW     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
`ifdef ANIM_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic [ADDR_W-1:0]     ram_addr_x,
    input  logic [ADDR_W-1:0]     ram_addr_y,
    output logic [FW+2*ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]      rom_data,
    output logic [PIX_W-1:0]      ram_data,
    output logic [FW-1:0]         frame,
    output logic                  busy,
    output logic                  done
);
    import anim_pkg::*;

    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);

    anim_state_t       state_q, state_d;
    anim_mode_t        mode_q, mode_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              dir_up_q, dir_up_d;
    logic              done_q, done_d;
    logic [PIX_W-1:0]  ram_data_q;

    logic tick;
    logic pause_w;
    logic presc_clr;
    logic presc_en;

`ifdef ANIM_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // Prescaler is held at zero outside RUN and restarted by start/stop so the
    // first advance always lands TICKS cycles after entering RUN.
    assign presc_clr = (state_q != RUN) || start || stop;
    assign presc_en  = (state_q == RUN) && !pause_w;

    frame_tick #(
        .TICKS (TICKS)
    ) u_frame_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        frame_d  = frame_q;
        dir_up_d = dir_up_q;
        done_d   = 1'b0;

        if (stop) begin
            state_d  = IDLE;
            frame_d  = '0;
            dir_up_d = 1'b1;
        end else if (start) begin
            // start overrides any tick in the same cycle, so no done here.
            state_d  = RUN;
            frame_d  = '0;
            dir_up_d = 1'b1;
            mode_d   = decode_mode(mode);
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        case (mode_q)
                            PINGPONG: begin
                                // Endpoints are shown once: flip and step away
                                // on the same tick. A single frame never moves.
                                if (dir_up_q) begin
                                    if (frame_q == LAST_FRAME) begin
                                        if (FRAMES > 1) begin
                                            frame_d  = frame_q - FW'(1);
                                            dir_up_d = 1'b0;
                                        end
                                    end else begin
                                        frame_d = frame_q + FW'(1);
                                    end
                                end else begin
                                    if (frame_q == '0) begin
                                        if (FRAMES > 1) begin
                                            frame_d  = frame_q + FW'(1);
                                            dir_up_d = 1'b1;
                                        end
                                    end else begin
                                        frame_d = frame_q - FW'(1);
                                    end
                                end
                            end
                            ONESHOT: begin
                                if (frame_q == LAST_FRAME) begin
                                    state_d = HOLD;
                                    done_d  = 1'b1;
                                end else begin
                                    frame_d = frame_q + FW'(1);
                                end
                            end
                            default: begin
                                frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FW'(1);
                            end
                        endcase
                    end
                end
                HOLD: begin
                    frame_d = frame_q;
                end
                default: begin
                    state_d = IDLE;
                    frame_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= LOOP;
            frame_q    <= '0;
            dir_up_q   <= 1'b1;
            done_q     <= 1'b0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            frame_q    <= frame_d;
            dir_up_q   <= dir_up_d;
            done_q     <= done_d;
            ram_data_q <= rom_data;
        end
    end

    assign rom_addr = {frame_q, ram_addr_y, ram_addr_x};
    assign ram_data = ram_data_q;
    assign frame    = frame_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
module tb_anim_sequencer;

    localparam int FRAMES = 4;
    localparam int TICKS  = 3;
    localparam int PIX_W  = 16;
    localparam int ADDR_W = 8;
    localparam int FW     = 2;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    stop;
    logic [1:0]              mode;
    logic                    pause;
    logic [ADDR_W-1:0]       ram_addr_x;
    logic [ADDR_W-1:0]       ram_addr_y;
    logic [FW+2*ADDR_W-1:0]  rom_addr;
    logic [PIX_W-1:0]        rom_data;
    logic [PIX_W-1:0]        ram_data;
    logic [FW-1:0]           frame;
    logic                    busy;
    logic                    done;

    int n_cmp;
    int n_bad;

    anim_sequencer #(
        .FRAMES (FRAMES),
        .TICKS  (TICKS),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
`ifdef ANIM_PAUSE_EN
        .pause      (pause),
`endif
        .ram_addr_x (ram_addr_x),
        .ram_addr_y (ram_addr_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_data   (ram_data),
        .frame      (frame),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'd0;   // later mode changes must be ignored
    endtask

    int loop_seq [6];
    int pp_seq   [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        loop_seq = '{0, 1, 2, 3, 0, 1};
        pp_seq   = '{0, 1, 2, 3, 2, 1, 0, 1};

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; pause = 1'b0;
        ram_addr_x = 8'd0; ram_addr_y = 8'd0; rom_data = 16'h1234;
        repeat (3) step();
        check("rst_ram_data", 32'(ram_data), 32'h0);
        check("rst_frame",    32'(frame),    32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_done",     32'(done),     32'h0);

        // Idle after reset
        rst = 1'b0; rom_data = 16'h0000;
        ram_addr_x = 8'd5; ram_addr_y = 8'd9;
        repeat (20) step();
        check("idle_frame",    32'(frame),    32'h0);
        check("idle_busy",     32'(busy),     32'h0);
        check("idle_done",     32'(done),     32'h0);
        check("idle_ram_data", 32'(ram_data), 32'h0);
        check("idle_rom_addr", 32'(rom_addr), 32'h00905);

        // Loop mode: 0,1,2,3,0,1 at 3 cycles each
        do_start(2'd0);
        for (int i = 0; i < 18; i++) begin
            check($sformatf("loop_frame_%0d", i), 32'(frame), 32'(loop_seq[i/3]));
            check($sformatf("loop_busy_%0d", i),  32'(busy),  32'h1);
            check($sformatf("loop_done_%0d", i),  32'(done),  32'h0);
            if (i == 4) check("loop_rom_addr", 32'(rom_addr), 32'h10905);
            step();
        end

        // Ping-pong: 0,1,2,3,2,1,0,1
        do_start(2'd1);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("pp_frame_%0d", i), 32'(frame), 32'(pp_seq[i/3]));
            check($sformatf("pp_done_%0d", i),  32'(done),  32'h0);
            step();
        end

        // One-shot: 0..3, done 12 cycles after start, then HOLD at 3
        do_start(2'd2);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("os_frame_%0d", i), 32'(frame), 32'(i/3));
            check($sformatf("os_busy_%0d", i),  32'(busy),  32'h1);
            check($sformatf("os_done_%0d", i),  32'(done),  32'h0);
            step();
        end
        check("os_done_pulse", 32'(done),  32'h1);
        check("os_busy_fall",  32'(busy),  32'h0);
        check("os_hold_frame", 32'(frame), 32'h3);
        step();
        check("os_done_once",  32'(done),  32'h0);
        repeat (5) step();
        check("os_hold_stay",  32'(frame), 32'h3);
        check("os_hold_busy",  32'(busy),  32'h0);

        // One-shot restarted on its final tick: start wins, no done
        do_start(2'd2);
        repeat (11) step();
        check("os_pre_final", 32'(frame), 32'h3);
        mode = 2'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("os_restart_done",  32'(done),  32'h0);
        check("os_restart_frame", 32'(frame), 32'h0);
        check("os_restart_busy",  32'(busy),  32'h1);
        step();
        check("os_restart_done2", 32'(done),  32'h0);

        // start together with stop: stop wins
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_busy",  32'(busy),  32'h0);
        check("ss_frame", 32'(frame), 32'h0);

        // stop mid-run
        do_start(2'd0);
        repeat (4) step();
        check("mid_frame", 32'(frame), 32'h1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_busy",  32'(busy),  32'h0);
        check("stop_frame", 32'(frame), 32'h0);
        repeat (4) step();
        check("stop_stays", 32'(frame), 32'h0);

        // Pixel register
        ram_addr_x = 8'd5; ram_addr_y = 8'd7; rom_data = 16'hF800;
        #1;
        check("pix_rom_addr", 32'(rom_addr), 32'h00705);
        step();
        check("pix_ram_data", 32'(ram_data), 32'hF800);
        rom_data = 16'h07E0;
        step();
        check("pix_ram_data2", 32'(ram_data), 32'h07E0);

        // Reset mid-run
        do_start(2'd2);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmid_frame",    32'(frame),    32'h0);
        check("rmid_busy",     32'(busy),     32'h0);
        check("rmid_done",     32'(done),     32'h0);
        check("rmid_ram_data", 32'(ram_data), 32'h0);

`ifdef ANIM_PAUSE_EN
        // Pause at frame 2 after one elapsed count: advance follows TICKS-1 later
        do_start(2'd0);
        repeat (7) step();
        check("pz_frame_pre", 32'(frame), 32'h2);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("pz_hold_%0d", i), 32'(frame), 32'h2);
            check($sformatf("pz_busy_%0d", i), 32'(busy),  32'h1);
        end
        pause = 1'b0;
        step();
        check("pz_rel_1", 32'(frame), 32'h2);
        step();
        check("pz_rel_2", 32'(frame), 32'h3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("pz_stop", 32'(frame), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Parametrised sprite-animation sequencer for the pet display path. Steps a frame index through `FRAMES` sprite frames at a programmable rate, in loop, ping-pong or one-shot mode. Forms the frame-memory address from the frame index and the pixel coordinates supplied by the VGA scanner. Registers the returned pixel towards the display mux. Replaces the fixed-step idle animator and serves every character animation (idle, eat, sleep, play).

## Interface
- `FRAMES`, default 8: number of frames in the sequence, ≥1; `FW = max($clog2(FRAMES),1)`.
- `TICKS`, default 25_000_000: clock cycles per frame, ≥1.
- `PIX_W`, default 16: pixel width, RGB565.
- `ADDR_W`, default 8: width of each pixel coordinate.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; (re)starts the sequence from frame 0.
- `stop` in 1: one-cycle pulse; returns to IDLE.
- `mode` in 2: 0 loop, 1 ping-pong, 2 one-shot, 3 treated as loop; sampled only on `start`.
- `pause` in 1: present only with `ANIM_PAUSE_EN`.
- `ram_addr_x` in ADDR_W: pixel column.
- `ram_addr_y` in ADDR_W: pixel row.
- `rom_addr` out FW+2·ADDR_W: `{frame, ram_addr_y, ram_addr_x}`, combinational.
- `rom_data` in PIX_W: pixel from the frame memory, combinational w.r.t. `rom_addr`.
- `ram_data` out PIX_W: registered pixel.
- `frame` out FW: current frame index.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when a one-shot sequence completes.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: `frame` = 0 (rest pose), prescaler cleared and stopped.
- RUN: prescaler counts 0..TICKS-1. `tick` fires in the cycle the count equals TICKS-1, then the count wraps to 0.
- On `tick`, by latched mode:
  - loop: `frame` = (frame==FRAMES-1) ? 0 : frame+1.
  - ping-pong: direction is up after start. At FRAMES-1 the direction flips and `frame` decrements; at 0 it flips and `frame` increments. The sequence is 0,1,..,N-1,N-2,..,0,1…, with no repeated endpoint frames. With FRAMES==1, `frame` stays 0.
  - one-shot: increment. A tick while `frame`==FRAMES-1 moves the state to HOLD, keeps `frame` at FRAMES-1 and pulses `done`.
- HOLD: last frame is displayed; prescaler stopped; `busy` = 0.
- `start` in any state: `frame` ← 0, direction ← up, prescaler ← 0, mode latched, state ← RUN.
- `stop` in any state: state ← IDLE, `frame` ← 0.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` on the same cycle as a tick: `start` wins, and no `done` is produced.
- Mode changes outside `start` are ignored.
- Reset values: state IDLE, `frame` 0, direction up, prescaler 0, `ram_data` 0, `busy` 0, `done` 0.

## Timing
- `start` at cycle c: `busy` = 1 from c+1. First advance to frame 1 happens at c+TICKS (`frame`=1 visible at c+TICKS+1).
- `ram_data` = `rom_data` registered, one cycle after `rom_addr`. The scanner compensates for this latency.
- `done` is high for exactly one cycle, the cycle after the final tick, coincident with entry to HOLD.
- Reset mid-run: the next cycle shows reset values; no `done`.

## Configuration
- `ANIM_PAUSE_EN` defined: adds the `pause` input.
  - While `pause`=1 in RUN, the prescaler and `frame` freeze and `busy` stays 1.
  - `start` and `stop` still act while paused.
- `ANIM_PAUSE_EN` undefined: no `pause` port; the prescaler always runs in RUN.

## Structure
- Package `anim_pkg`: `anim_mode_t` (LOOP, PINGPONG, ONESHOT), `anim_state_t` (IDLE, RUN, HOLD).
- Sub-module `frame_tick`: a TICKS-cycle prescaler with synchronous clear and enable, emitting the one-cycle `tick`.
- The top level holds the FSM, frame/direction registers, address concatenation and the pixel register.

## Test plan
All scenarios use FRAMES=4, TICKS=3.
- Reset then idle 20 cycles → `frame`=0, `busy`=0, `done`=0, `ram_data`=0; `rom_addr`={0,y,x}.
- Loop: `start`, mode 0 → `frame` sequence 0,1,2,3,0,1 changing every 3 cycles; `done` never asserts.
- Ping-pong: `start`, mode 1 → 0,1,2,3,2,1,0,1.
- One-shot: `start`, mode 2 → 0,1,2,3, then HOLD with `frame`=3. `done` pulses once, 12 cycles after `start`; `busy` falls the same cycle.
- `start`+`stop` in the same cycle, then `stop` mid-run → IDLE each time, `frame`=0. `rom_data`=16'hF800 at x=5, y=7 → `ram_data`=16'hF800 one cycle later.
- `ANIM_PAUSE_EN`: `pause` high for 10 cycles while at frame 2 → `frame` stays 2; after release, the advance to 3 comes exactly TICKS minus the count already elapsed later.
